note_judge: RTL and testbench
=============================

Name: note_judge

Overview:
- Player-side receiving end of the note sender stream.
- Each eighth-beat step, it captures the expected 5-bit fret chord (exp_notes) and opens a hit window.
- It judges the player's strum and fret inputs against that chord and emits hit/miss pulses.
- It keeps a running combo, score multiplier and saturating score for the display/scoreboard logic.

Parameters:
- SCORE_W, 16: score register width.
- HIT_POINTS, 10: base points per hit, before the multiplier.
- COMBO_STEP, 8: consecutive hits per multiplier increment.
- MAX_MULT, 4: multiplier ceiling.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- eight_beat  input  1  one-cycle pulse marking each eighth-beat step (same tick that drives the note sender).
- load  input  1  song section active; low = judging disabled.
- exp_notes  input  5  expected chord for the current step; bit per fret; 0 = no note.
- frets  input  5  debounced fret buttons held by the player, level.
- strum  input  1  debounced strum bar, level; rising edge = strum event.
- hit_pulse  output  1  one-cycle pulse per judged hit.
- miss_pulse  output  1  one-cycle pulse per judged miss.
- combo  output  8  consecutive-hit count, saturates at 255.
- multiplier  output  3  current multiplier, range 1..MAX_MULT.
- score  output  SCORE_W  accumulated score, saturating.

Behaviour:
- Reset, synchronous and active-high, wins over all other inputs. It sets:
  - state=IDLE, pending=0, strum_q=0
  - hit_pulse=0, miss_pulse=0
  - combo=0, multiplier=1, score=0
- Strum event: strum_evt = strum & ~strum_q. strum_q registers strum every cycle.
- States:
  - IDLE: load=0; no judging; pending held at 0.
  - OPEN: pending≠0 and not yet judged.
  - CLOSED: pending=0, or pending already judged.
- Transitions:
  - Any state with load=0 → IDLE at the next edge; pending cleared. combo and score are retained.
  - IDLE with load=1 → CLOSED.
  - On eight_beat with load=1, pending ← exp_notes. Next state is OPEN if exp_notes≠0, else CLOSED.
- Judging in OPEN on strum_evt:
  - frets==pending exactly → hit; state CLOSED.
  - Otherwise → miss; state CLOSED.
- Window expiry: eight_beat arriving while state is OPEN → miss for the old note, then the new capture proceeds.
- Simultaneous strum_evt and eight_beat: the strum is judged against the old pending, the new exp_notes is captured, and one pulse results. Window expiry does not add a second miss.
- Strum in CLOSED: handled by the optional feature.
- Latency: the verdict is registered. hit_pulse/miss_pulse is high for exactly one cycle following the edge at which strum_evt or eight_beat was sampled. combo, multiplier and score update on that same edge.
- At most one of hit_pulse and miss_pulse is high in any cycle.
- Hit arithmetic:
  - points = HIT_POINTS × multiplier, using the pre-update multiplier.
  - score ← min(score+points, 2^SCORE_W−1); the sum is computed in SCORE_W+1 bits.
  - combo ← min(combo+1, 255).
- Miss: combo ← 0; score unchanged.
- Multiplier: registered, recomputed from the new combo on the same edge as the verdict. multiplier = min(MAX_MULT, 1 + combo/COMBO_STEP).
- Reset mid-window: pending discarded, no pulse emitted, all counters cleared.

Optional Feature:
- Macro: NOTE_JUDGE_OVERSTRUM_EN.
- Defined: strum_evt while CLOSED (load=1) → miss_pulse, combo cleared, score unchanged.
- Undefined: strum_evt in CLOSED or IDLE is ignored; no pulse, no state change.
- In both builds, a strum in IDLE is always ignored.

Test Plan:
1. Reset, load=1. eight_beat with exp_notes=10101, then frets=10101 and strum rise 3 cycles later → one hit_pulse; combo=1, multiplier=1, score=10.
2. Capture 01110, frets=01100, strum → miss_pulse; combo=0, score unchanged. A second strum in the same window → no pulse without the macro, miss_pulse with it.
3. Capture 00100, no strum until the next eight_beat (exp_notes=00001) → exactly one miss_pulse one cycle after that eight_beat; new window OPEN on 00001.
4. Strum_evt and eight_beat in the same cycle, with old pending 00010 and frets=00010, new exp_notes=00001 → single hit_pulse; the new window judges against 00001.
5. 40 consecutive hits → multiplier steps 1→2 after combo 8, →3 after 16, →4 after 24, stays 4 after 32. Score = 10·8 + 20·8 + 30·8 + 40·16 = 1120.
6. SCORE_W=8, repeated hits → score saturates at 255 and never wraps. Assert reset mid-window → all outputs return to their reset values with no pulse.

Source files
------------

// File: rtl/note_judge_if.sv
// Player-input / judge-output bundle between the game front-end and note_judge.
// master drives the chord, buttons and beat tick; slave returns verdicts and tallies.
interface note_judge_if #(
  parameter int SCORE_W = 16
);
  logic               eight_beat;
  logic               load;
  logic [4:0]         exp_notes;
  logic [4:0]         frets;
  logic               strum;
  logic               hit_pulse;
  logic               miss_pulse;
  logic [7:0]         combo;
  logic [2:0]         multiplier;
  logic [SCORE_W-1:0] score;

  modport master (
    output eight_beat, load, exp_notes, frets, strum,
    input  hit_pulse, miss_pulse, combo, multiplier, score
  );

  modport slave (
    input  eight_beat, load, exp_notes, frets, strum,
    output hit_pulse, miss_pulse, combo, multiplier, score
  );
endinterface

// File: rtl/note_judge.sv
// Judges strums against the per-step chord; keeps combo, multiplier, saturating score (overstrum: NOTE_JUDGE_OVERSTRUM_EN).
// Latency: verdict pulses and tallies are registered, visible one cycle after the sampled strum/beat.
// Backpressure: none; inputs are sampled every cycle and verdicts are never stalled.
module note_judge #(
  parameter int SCORE_W    = 16,
  parameter int HIT_POINTS = 10,
  parameter int COMBO_STEP = 8,
  parameter int MAX_MULT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  note_judge_if.slave bus
);

  localparam int SW1 = SCORE_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [4:0]         pending, pending_n;
  logic               strum_q;
  logic               strum_evt;
  logic               hit_n, miss_n;
  logic               hit_r, miss_r;
  logic [7:0]         combo_r, combo_n;
  logic [2:0]         mult_r, mult_n;
  logic [SCORE_W-1:0] score_r, score_n;
  logic [SCORE_W:0]   points;
  logic [SCORE_W:0]   sum;
  logic [8:0]         mult_calc;

  assign strum_evt = bus.strum & ~strum_q;

  // Verdict and window control. A strum in OPEN takes precedence over window
  // expiry, so a simultaneous strum and beat produce exactly one verdict.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    hit_n     = 1'b0;
    miss_n    = 1'b0;

    if (!bus.load) begin
      state_n   = IDLE;
      pending_n = '0;
    end else begin
      if (state == IDLE)
        state_n = CLOSED;

      if (state == OPEN && strum_evt) begin
        if (bus.frets == pending)
          hit_n = 1'b1;
        else
          miss_n = 1'b1;
        state_n = CLOSED;
      end else if (state == OPEN && bus.eight_beat) begin
        miss_n = 1'b1;
`ifdef NOTE_JUDGE_OVERSTRUM_EN
      end else if (state == CLOSED && strum_evt) begin
        miss_n = 1'b1;
`endif
      end

      if (bus.eight_beat) begin
        pending_n = bus.exp_notes;
        state_n   = (bus.exp_notes != 5'd0) ? OPEN : CLOSED;
      end
    end
  end

  // Tally update; points use the multiplier in force before this verdict.
  always_comb begin
    combo_n = combo_r;
    score_n = score_r;
    points  = SW1'(HIT_POINTS) * SW1'(mult_r);
    sum     = {1'b0, score_r} + points;

    if (hit_n) begin
      combo_n = (combo_r == 8'hFF) ? combo_r : combo_r + 8'd1;
      score_n = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    end else if (miss_n) begin
      combo_n = '0;
    end

    mult_calc = 9'(combo_n / 8'(COMBO_STEP)) + 9'd1;
    mult_n    = (mult_calc > 9'(MAX_MULT)) ? 3'(MAX_MULT) : mult_calc[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      strum_q <= 1'b0;
      hit_r   <= 1'b0;
      miss_r  <= 1'b0;
      combo_r <= '0;
      mult_r  <= 3'd1;
      score_r <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      strum_q <= bus.strum;
      hit_r   <= hit_n;
      miss_r  <= miss_n;
      combo_r <= combo_n;
      mult_r  <= mult_n;
      score_r <= score_n;
    end
  end

  assign bus.hit_pulse  = hit_r;
  assign bus.miss_pulse = miss_r;
  assign bus.combo      = combo_r;
  assign bus.multiplier = mult_r;
  assign bus.score      = score_r;

  a_one_verdict: assert property (@(posedge clk) !(hit_r && miss_r));

endmodule

// File: tb/tb_note_judge.sv
// Directed table-driven bench for note_judge; a 16-bit and an 8-bit score instance share stimulus.
module tb_note_judge;

`ifdef NOTE_JUDGE_OVERSTRUM_EN
  localparam bit OVS = 1'b1;
`else
  localparam bit OVS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  note_judge_if #(.SCORE_W(16)) bus16 ();
  note_judge_if #(.SCORE_W(8))  bus8 ();

  note_judge #(.SCORE_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  note_judge #(.SCORE_W(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic       rst, ld, eb;
    logic [4:0] ex, fr;
    logic       st;
    logic       hit, miss;
    logic [7:0] combo;
    logic [2:0] mult;
    logic [15:0] score;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t v(logic rst, logic ld, logic eb, logic [4:0] ex, logic [4:0] fr,
                             logic st, logic hit, logic miss, logic [7:0] combo,
                             logic [2:0] mult, logic [15:0] score);
    vec_t r;
    r.rst = rst; r.ld = ld; r.eb = eb; r.ex = ex; r.fr = fr; r.st = st;
    r.hit = hit; r.miss = miss; r.combo = combo; r.mult = mult; r.score = score;
    return r;
  endfunction

  task automatic cyc(input logic rst, input logic ld, input logic eb, input logic [4:0] ex,
                     input logic [4:0] fr, input logic st);
    @(negedge clk);
    reset = rst;
    bus16.load = ld; bus16.eight_beat = eb; bus16.exp_notes = ex; bus16.frets = fr; bus16.strum = st;
    bus8.load  = ld; bus8.eight_beat  = eb; bus8.exp_notes  = ex; bus8.frets  = fr; bus8.strum  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s16, s8, mb, me;

    //             rst ld eb ex        fr        st  hit miss combo mult score
    tbl[0]  = v(1, 1, 0, 5'b00000, 5'b00000, 0,  0, 0,   0, 1,  0);
    tbl[1]  = v(0, 1, 0, 5'b00000, 5'b00000, 0,  0, 0,   0, 1,  0);
    tbl[2]  = v(0, 1, 1, 5'b10101, 5'b00000, 0,  0, 0,   0, 1,  0);
    tbl[3]  = v(0, 1, 0, 5'b00000, 5'b00000, 0,  0, 0,   0, 1,  0);
    tbl[4]  = v(0, 1, 0, 5'b00000, 5'b10101, 0,  0, 0,   0, 1,  0);
    tbl[5]  = v(0, 1, 0, 5'b00000, 5'b10101, 1,  1, 0,   1, 1, 10);
    tbl[6]  = v(0, 1, 0, 5'b00000, 5'b10101, 1,  0, 0,   1, 1, 10);
    tbl[7]  = v(0, 1, 0, 5'b00000, 5'b10101, 0,  0, 0,   1, 1, 10);
    tbl[8]  = v(0, 1, 1, 5'b01110, 5'b01100, 0,  0, 0,   1, 1, 10);
    tbl[9]  = v(0, 1, 0, 5'b00000, 5'b01100, 1,  0, 1,   0, 1, 10);
    tbl[10] = v(0, 1, 0, 5'b00000, 5'b01100, 0,  0, 0,   0, 1, 10);
    tbl[11] = v(0, 1, 0, 5'b00000, 5'b01100, 1,  0, OVS, 0, 1, 10);
    tbl[12] = v(0, 1, 0, 5'b00000, 5'b01100, 0,  0, 0,   0, 1, 10);
    tbl[13] = v(0, 1, 1, 5'b00100, 5'b01100, 0,  0, 0,   0, 1, 10);
    tbl[14] = v(0, 1, 0, 5'b00000, 5'b01100, 0,  0, 0,   0, 1, 10);
    tbl[15] = v(0, 1, 1, 5'b00001, 5'b01100, 0,  0, 1,   0, 1, 10);
    tbl[16] = v(0, 1, 0, 5'b00000, 5'b00001, 1,  1, 0,   1, 1, 20);
    tbl[17] = v(0, 1, 0, 5'b00000, 5'b00001, 0,  0, 0,   1, 1, 20);
    tbl[18] = v(0, 1, 1, 5'b00010, 5'b00010, 0,  0, 0,   1, 1, 20);
    tbl[19] = v(0, 1, 1, 5'b00001, 5'b00010, 1,  1, 0,   2, 1, 30);
    tbl[20] = v(0, 1, 0, 5'b00000, 5'b00001, 0,  0, 0,   2, 1, 30);
    tbl[21] = v(0, 1, 0, 5'b00000, 5'b00001, 1,  1, 0,   3, 1, 40);
    tbl[22] = v(0, 1, 0, 5'b00000, 5'b00001, 0,  0, 0,   3, 1, 40);
    tbl[23] = v(0, 1, 1, 5'b00100, 5'b00001, 0,  0, 0,   3, 1, 40);
    tbl[24] = v(0, 0, 0, 5'b00000, 5'b00100, 0,  0, 0,   3, 1, 40);
    tbl[25] = v(0, 0, 0, 5'b00000, 5'b00100, 1,  0, 0,   3, 1, 40);
    tbl[26] = v(0, 0, 0, 5'b00000, 5'b00100, 0,  0, 0,   3, 1, 40);
    tbl[27] = v(0, 1, 0, 5'b00000, 5'b00100, 0,  0, 0,   3, 1, 40);
    tbl[28] = v(0, 1, 0, 5'b00000, 5'b00100, 1,  0, OVS, OVS ? 8'd0 : 8'd3, 1, 40);

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].rst, tbl[i].ld, tbl[i].eb, tbl[i].ex, tbl[i].fr, tbl[i].st);
      chk($sformatf("v%0d.hit", i),   32'(bus16.hit_pulse),  32'(tbl[i].hit));
      chk($sformatf("v%0d.miss", i),  32'(bus16.miss_pulse), 32'(tbl[i].miss));
      chk($sformatf("v%0d.combo", i), 32'(bus16.combo),      32'(tbl[i].combo));
      chk($sformatf("v%0d.mult", i),  32'(bus16.multiplier), 32'(tbl[i].mult));
      chk($sformatf("v%0d.score", i), 32'(bus16.score),      32'(tbl[i].score));
    end

    // 40 consecutive hits: multiplier ramp on the 16-bit score, saturation on the 8-bit one
    cyc(1, 1, 0, 5'b00000, 5'b00000, 0);
    chk("rst8.score", 32'(bus8.score), 0);
    chk("rst8.mult",  32'(bus8.multiplier), 1);
    cyc(0, 1, 0, 5'b00000, 5'b00000, 0);
    s16 = 0;
    s8  = 0;
    for (int k = 1; k <= 40; k++) begin
      mb  = (1 + (k - 1) / 8 > 4) ? 4 : 1 + (k - 1) / 8;
      me  = (1 + k / 8 > 4) ? 4 : 1 + k / 8;
      s16 = s16 + 10 * mb;
      s8  = (s8 + 10 * mb > 255) ? 255 : s8 + 10 * mb;
      cyc(0, 1, 1, 5'b00011, 5'b00011, 0);
      cyc(0, 1, 0, 5'b00000, 5'b00011, 1);
      chk($sformatf("run%0d.hit", k),     32'(bus16.hit_pulse),  1);
      chk($sformatf("run%0d.combo", k),   32'(bus16.combo),      32'(k));
      chk($sformatf("run%0d.mult", k),    32'(bus16.multiplier), 32'(me));
      chk($sformatf("run%0d.score", k),   32'(bus16.score),      32'(s16));
      chk($sformatf("run%0d.score8", k),  32'(bus8.score),       32'(s8));
      cyc(0, 1, 0, 5'b00000, 5'b00011, 0);
    end
    chk("run.final_score", 32'(bus16.score), 1120);
    chk("run.final_score8", 32'(bus8.score), 255);

    // reset asserted in an open window alongside a matching strum
    cyc(0, 1, 1, 5'b00100, 5'b00100, 0);
    cyc(1, 1, 0, 5'b00000, 5'b00100, 1);
    chk("midrst.hit",    32'(bus16.hit_pulse),  0);
    chk("midrst.miss",   32'(bus16.miss_pulse), 0);
    chk("midrst.combo",  32'(bus16.combo),      0);
    chk("midrst.mult",   32'(bus16.multiplier), 1);
    chk("midrst.score",  32'(bus16.score),      0);
    chk("midrst.score8", 32'(bus8.score),       0);
    chk("midrst.hit8",   32'(bus8.hit_pulse),   0);
    cyc(0, 1, 0, 5'b00000, 5'b00100, 1);
    chk("postrst.hit",   32'(bus16.hit_pulse),  0);
    chk("postrst.miss",  32'(bus16.miss_pulse), 0);
    cyc(0, 1, 0, 5'b00000, 5'b00100, 0);
    chk("postrst.combo", 32'(bus16.combo),      0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
